imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_imem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Shares one synchronous instruction memory port between a CPU fetch port and
// a program-load write port. After reset the block sits in BOOT, where only
// loads are served. A load_done pulse moves it to RUN, where fetches and
// loads are arbitrated. It leaves RUN only on reset.
//
// Build option:
//   IMEM_ARB_RR_EN  defined   -> RUN-state conflicts resolved round-robin
//                   undefined -> load always wins a RUN-state conflict
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   fetch_req/addr      CPU fetch request and byte address (held until gnt)
//   fetch_gnt           fetch accepted this cycle (combinational)
//   fetch_valid/data    fetch result, one cycle after fetch_gnt
//   load_req/addr/data  program-load write request (held until gnt)
//   load_gnt            load accepted this cycle (combinational)
//   load_done           one-cycle pulse, program image complete
//   mem_addr/we/wdata   instruction memory word index, write enable, data
//   mem_rdata           memory read data, one cycle after mem_addr
//   running             high in RUN
//   addr_err            sticky flag, set by any granted out-of-range access
// -----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [31:0]       fetch_data,
    input  logic              load_req,
    input  logic [31:0]       load_addr,
    input  logic [31:0]       load_data,
    output logic              load_gnt,
    input  logic              load_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              running,
    output logic              addr_err
);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e      state_q;
    logic        fetch_valid_q;
    logic        fetch_oor_q;
    logic [31:0] data_hold_q;
    logic        addr_err_q;

    // Word indices; the two byte-offset bits are dropped.
    logic [29:0] fetch_idx;
    logic [29:0] load_idx;
    logic        fetch_oor;
    logic        load_oor;
    logic        conflict;
    logic        unused_byte_bits;

    assign fetch_idx        = fetch_addr[31:2];
    assign load_idx         = load_addr[31:2];
    assign unused_byte_bits = ^{fetch_addr[1:0], load_addr[1:0]};

    // Any index bit above the memory size marks the access out of range.
    assign fetch_oor = (fetch_idx >> ADDR_W) != '0;
    assign load_oor  = (load_idx >> ADDR_W) != '0;

    assign conflict = (state_q == StRun) && fetch_req && load_req;

`ifdef IMEM_ARB_RR_EN
    // High when the fetch side wins the next RUN-state conflict.
    logic prio_fetch_q;
`endif

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (!reset) begin
            if (state_q == StBoot) begin
                load_gnt = load_req;
            end else if (conflict) begin
`ifdef IMEM_ARB_RR_EN
                fetch_gnt = prio_fetch_q;
                load_gnt  = !prio_fetch_q;
`else
                load_gnt  = 1'b1;
`endif
            end else begin
                fetch_gnt = fetch_req;
                load_gnt  = load_req;
            end
        end
    end

    // Memory port drive; an out-of-range load is granted but never written.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (load_gnt) begin
            mem_addr  = load_idx[ADDR_W-1:0];
            mem_we    = !load_oor;
            mem_wdata = load_data;
        end else if (fetch_gnt) begin
            mem_addr  = fetch_idx[ADDR_W-1:0];
        end
    end

    // Memory data is passed straight through in the cycle after the grant;
    // otherwise the last delivered word is held.
    always_comb begin
        fetch_data = data_hold_q;
        if (fetch_valid_q) begin
            fetch_data = fetch_oor_q ? 32'h0 : mem_rdata;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign addr_err    = addr_err_q;
    assign running     = (state_q == StRun);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StBoot;
            fetch_valid_q <= 1'b0;
            fetch_oor_q   <= 1'b0;
            data_hold_q   <= 32'h0;
            addr_err_q    <= 1'b0;
`ifdef IMEM_ARB_RR_EN
            prio_fetch_q  <= 1'b1;
`endif
        end else begin
            unique case (state_q)
                StBoot: if (load_done) state_q <= StRun;
                StRun:  state_q <= StRun;
            endcase

            fetch_valid_q <= fetch_gnt;
            fetch_oor_q   <= fetch_gnt && fetch_oor;

            if (fetch_valid_q) begin
                data_hold_q <= fetch_data;
            end

            if ((fetch_gnt && fetch_oor) || (load_gnt && load_oor)) begin
                addr_err_q <= 1'b1;
            end

`ifdef IMEM_ARB_RR_EN
            if (conflict) begin
                prio_fetch_q <= !prio_fetch_q;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Directed and randomized bench for imem_arbiter. A behavioural memory model
// serves the DUT memory port. A separate reference array, together with a
// cycle-level model of grants, status and fetch results, gives every expected
// value. Inputs change on the falling edge and are checked 1 time unit later.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;

    localparam int unsigned AW = 11;
    localparam int unsigned WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fetch_req = 1'b0;
    logic [31:0]   fetch_addr = '0;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [31:0]   fetch_data;
    logic          load_req = 1'b0;
    logic [31:0]   load_addr = '0;
    logic [31:0]   load_data = '0;
    logic          load_gnt;
    logic          load_done = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic          running;
    logic          addr_err;

    int checks = 0;
    int errors = 0;

    // Memory seen by the DUT.
    logic [31:0] tmem [0:WORDS-1];
    // Reference contents kept by the model.
    logic [31:0] ref_mem [0:WORDS-1];

    // Reference model state.
    bit          m_run;
    bit          m_fetch_turn;
    bit          m_err;
    bit          m_fv;
    logic [31:0] m_fd;
    bit          last_fg;
    bit          last_lg;

    imem_arbiter #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_gnt  (fetch_gnt),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .load_req   (load_req),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_gnt   (load_gnt),
        .load_done  (load_done),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .running    (running),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) tmem[mem_addr] <= mem_wdata;
        mem_rdata <= tmem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 15) == 0) return $urandom | 32'h0000_2000;
        return 32'($urandom_range(0, 32'h1FFF));
    endfunction

    // One clock cycle. Entered just after a falling edge with inputs set;
    // returns on the next falling edge.
    task automatic step();
        logic [31:0] fi, li;
        bit          fo, lo, eg_f, eg_l, ewe;
        logic [31:0] ea, ew;
        fi = fetch_addr >> 2;
        li = load_addr >> 2;
        fo = (fi >= WORDS);
        lo = (li >= WORDS);

        eg_f = 0;
        eg_l = 0;
        if (!m_run) begin
            eg_l = load_req;
        end else if (fetch_req && load_req) begin
`ifdef IMEM_ARB_RR_EN
            eg_f = m_fetch_turn;
            eg_l = !m_fetch_turn;
`else
            eg_l = 1;
`endif
        end else begin
            eg_f = fetch_req;
            eg_l = load_req;
        end

        ea = 0; ew = 0; ewe = 0;
        if (eg_l) begin
            ea = li % WORDS; ew = load_data; ewe = !lo;
        end else if (eg_f) begin
            ea = fi % WORDS;
        end

        #1;
        chk("fetch_gnt", 32'(fetch_gnt), 32'(eg_f));
        chk("load_gnt", 32'(load_gnt), 32'(eg_l));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_addr", 32'(mem_addr), ea);
        chk("mem_wdata", mem_wdata, ew);
        chk("fetch_valid", 32'(fetch_valid), 32'(m_fv));
        chk("fetch_data", fetch_data, m_fd);
        chk("running", 32'(running), 32'(m_run));
        chk("addr_err", 32'(addr_err), 32'(m_err));

        @(posedge clk);
        if (eg_f) begin
            m_fv = 1;
            m_fd = fo ? 32'h0 : ref_mem[fi % WORDS];
        end else begin
            m_fv = 0;
        end
        if (eg_l && !lo) ref_mem[li % WORDS] = load_data;
        if ((eg_f && fo) || (eg_l && lo)) m_err = 1;
        if (m_run && fetch_req && load_req) m_fetch_turn = !m_fetch_turn;
        if (!m_run && load_done) m_run = 1;
        last_fg = eg_f;
        last_lg = eg_l;
        @(negedge clk);
    endtask

    // Asynchronous reset entered on a falling edge, checked at once.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
        chk("rst_fetch_data", fetch_data, 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);
        chk("rst_fetch_gnt", 32'(fetch_gnt), 32'h0);
        chk("rst_load_gnt", 32'(load_gnt), 32'h0);
        m_run = 0;
        m_fetch_turn = 1;
        m_err = 0;
        m_fv = 0;
        m_fd = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) begin
            ref_mem[i] = $urandom;
            tmem[i] = ref_mem[i];
        end
        @(negedge clk);
        do_reset();

        // Fetch requested in BOOT is never granted.
        fetch_req = 1; fetch_addr = 32'h0;
        repeat (3) step();

        // BOOT loads; the second one hits the same word through byte offset 1.
        load_req = 1; load_addr = 32'h8; load_data = 32'hDEAD_BEEF;
        step();
        load_addr = 32'h9; load_data = 32'h0000_1234;
        step();
        load_req = 0;

        load_done = 1;
        step();
        load_done = 0;

        // First RUN fetch, then idle to see the result.
        fetch_req = 1; fetch_addr = 32'hB;
        step();
        fetch_req = 0;
        step();
        chk("boot_image_word", ref_mem[2], 32'h0000_1234);

        // Both held for four cycles.
        fetch_req = 1; fetch_addr = 32'h10;
        load_req = 1; load_addr = 32'h20; load_data = 32'hA5A5_0001;
        repeat (4) step();
        fetch_req = 0; load_req = 0;
        step();

        // Out-of-range fetch and load.
        fetch_req = 1; fetch_addr = 32'h0000_2000;
        step();
        fetch_req = 0;
        step();
        load_req = 1; load_addr = 32'h0000_2000; load_data = 32'hFFFF_FFFF;
        step();
        load_req = 0;
        step();

        // Reset right after a fetch grant discards the fetch.
        fetch_req = 1; fetch_addr = 32'h4;
        step();
        do_reset();
        fetch_req = 0;
        repeat (2) step();

        // Randomized traffic: BOOT first, load_done partway through.
        for (int i = 0; i < 400; i++) begin
            load_done = (i == 100 || i == 250);
            if (!fetch_req || last_fg) begin
                fetch_req = $urandom_range(0, 1);
                fetch_addr = rand_addr();
            end
            if (!load_req || last_lg) begin
                load_req = ($urandom_range(0, 2) == 0);
                load_addr = rand_addr();
                load_data = $urandom;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
